hs_pipe_fifo: RTL and testbench

- Parametrised successor to the single-word handshake pipeline stage used between the partial-product stages of the radix-Booth multiplier.
- Clocked 4-phase (return-to-zero) request/acknowledge handshake on both sides.
- Internal DEPTH-entry buffer of WIDTH-bit words, so a slow consumer does not immediately stall the producer.
- Generalises the one-word, one-slot stage in width and depth; adds occupancy flags and optional status/error reporting.

---
 rtl/hs_pipe_fifo.sv | 168 ++++++++++++++++
 tb/tb_hs_pipe_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_pipe_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hs_pipe_fifo
// Purpose  : 4-phase req/ack handshake pipeline stage with a DEPTH x WIDTH
//            FIFO buffer; `HS_STATUS_EN adds level and proto_err outputs.
// Revision : 1.0  initial release
// ============================================================================
module hs_pipe_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Rin,
  output logic             Ain,
  input  logic [WIDTH-1:0] data_in,
  output logic             Rout,
  input  logic             Aout,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef HS_STATUS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       proto_err
`endif
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

  typedef enum logic [0:0] {
    I_IDLE = 1'b0,
    I_ACK  = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_WAIT = 2'd2
  } out_state_t;

  in_state_t          r_in_state;
  out_state_t         r_out_state;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [WIDTH-1:0]   r_data_out;
  logic               r_rout;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);
  assign w_push  = (r_in_state == I_IDLE) && Rin && !w_full;
  assign w_pop   = (r_out_state == O_REQ) && Aout;

  assign Ain      = (r_in_state == I_ACK);
  assign Rout     = r_rout;
  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

  // Storage is never reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_state  <= I_IDLE;
      r_out_state <= O_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_rout      <= 1'b0;
    end else begin
      case (r_in_state)
        I_IDLE: begin
          if (w_push) begin
            r_wr_ptr   <= f_ptr_inc(r_wr_ptr);
            r_in_state <= I_ACK;
          end
        end
        I_ACK: begin
          if (!Rin) begin
            r_in_state <= I_IDLE;
          end
        end
        default: r_in_state <= I_IDLE;
      endcase

      case (r_out_state)
        O_IDLE: begin
          if (!w_empty) begin
            r_data_out  <= r_mem[r_rd_ptr];
            r_rout      <= 1'b1;
            r_out_state <= O_REQ;
          end
        end
        O_REQ: begin
          if (Aout) begin
            r_rd_ptr    <= f_ptr_inc(r_rd_ptr);
            r_rout      <= 1'b0;
            r_out_state <= O_WAIT;
          end
        end
        O_WAIT: begin
          if (!Aout) begin
            r_out_state <= O_IDLE;
          end
        end
        default: begin
          r_rout      <= 1'b0;
          r_out_state <= O_IDLE;
        end
      endcase

      // The word stays counted until its consumer acknowledge arrives.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef HS_STATUS_EN
  logic r_rin_q;
  logic r_proto_err;
  logic w_req_withdrawn;
  logic w_stray_ack;

  assign w_req_withdrawn = r_rin_q && !Rin && (r_in_state == I_IDLE);
  assign w_stray_ack     = Aout && (r_out_state == O_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rin_q     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_rin_q <= Rin;
      if (w_req_withdrawn || w_stray_ack) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign level     = r_count;
  assign proto_err = r_proto_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_pipe_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_pipe_fifo
// Purpose  : Directed vector table plus handshake sequences for hs_pipe_fifo.
// Revision : 1.0  initial release
// ============================================================================
module tb_hs_pipe_fifo;

  typedef struct {
    logic [5:0]  ctl;   // {rin, aout, ain, rout, full, empty}
    logic [63:0] din;
    logic [63:0] dout;
    logic [2:0]  lvl;
  } vec_t;

  localparam logic [63:0] c_word_a = 64'h0123_4567_89AB_CDEF;

  logic        clk;
  logic        reset;
  logic        rin0, aout0, ain0, rout0, full0, empty0;
  logic [63:0] din0, dout0;
  logic        rin1, aout1, ain1, rout1, full1, empty1;
  logic [63:0] din1, dout1;
`ifdef HS_STATUS_EN
  logic [2:0]  lvl0;
  logic [1:0]  lvl1;
  logic        perr0, perr1;
`endif

  int          n_cmp;
  int          n_bad;
  vec_t        tbl [28];
  logic [63:0] sw [10];
  logic        prod_done, cons_done;

  hs_pipe_fifo #(.WIDTH(64), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .Rin(rin0), .Ain(ain0), .data_in(din0),
    .Rout(rout0), .Aout(aout0), .data_out(dout0),
    .full(full0), .empty(empty0)
`ifdef HS_STATUS_EN
    , .level(lvl0), .proto_err(perr0)
`endif
  );

  hs_pipe_fifo #(.WIDTH(64), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .Rin(rin1), .Ain(ain1), .data_in(din1),
    .Rout(rout1), .Aout(aout1), .data_out(dout1),
    .full(full1), .empty(empty1)
`ifdef HS_STATUS_EN
    , .level(lvl1), .proto_err(perr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] ctl, input logic [63:0] din,
                              input logic [63:0] dout, input logic [2:0] lvl);
    vec_t v;
    v.ctl  = ctl;
    v.din  = din;
    v.dout = dout;
    v.lvl  = lvl;
    return v;
  endfunction

  task automatic push0(input logic [63:0] d);
    int n;
    din0 = d;
    rin0 = 1'b1;
    n = 0;
    while (ain0 !== 1'b1 && n < 40) begin tick(); n++; end
    chk("push_ack", ain0, 1);
    rin0 = 1'b0;
    n = 0;
    while (ain0 !== 1'b0 && n < 40) begin tick(); n++; end
    chk("push_rtz", ain0, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0;
    rin0 = 0; aout0 = 0; din0 = '0;
    rin1 = 0; aout1 = 0; din1 = '0;
    prod_done = 0; cons_done = 0;

    // Single transfer, then fill to full with a stalled consumer and drain.
    tbl[0]  = mk(6'b10_1000, c_word_a, 64'h0,    3'd1);
    tbl[1]  = mk(6'b00_0100, c_word_a, c_word_a, 3'd1);
    tbl[2]  = mk(6'b01_0001, c_word_a, c_word_a, 3'd0);
    tbl[3]  = mk(6'b00_0001, c_word_a, c_word_a, 3'd0);
    tbl[4]  = mk(6'b10_1000, 64'd1, c_word_a, 3'd1);
    tbl[5]  = mk(6'b00_0100, 64'd1, 64'd1, 3'd1);
    tbl[6]  = mk(6'b10_1100, 64'd2, 64'd1, 3'd2);
    tbl[7]  = mk(6'b00_0100, 64'd2, 64'd1, 3'd2);
    tbl[8]  = mk(6'b10_1100, 64'd3, 64'd1, 3'd3);
    tbl[9]  = mk(6'b00_0100, 64'd3, 64'd1, 3'd3);
    tbl[10] = mk(6'b10_1110, 64'd4, 64'd1, 3'd4);
    tbl[11] = mk(6'b00_0110, 64'd4, 64'd1, 3'd4);
    tbl[12] = mk(6'b10_0110, 64'd5, 64'd1, 3'd4);
    tbl[13] = mk(6'b10_0110, 64'd5, 64'd1, 3'd4);
    tbl[14] = mk(6'b11_0000, 64'd5, 64'd1, 3'd3);
    tbl[15] = mk(6'b10_1010, 64'd5, 64'd1, 3'd4);
    tbl[16] = mk(6'b00_0110, 64'd5, 64'd2, 3'd4);
    tbl[17] = mk(6'b01_0000, 64'd5, 64'd2, 3'd3);
    tbl[18] = mk(6'b00_0000, 64'd5, 64'd2, 3'd3);
    tbl[19] = mk(6'b00_0100, 64'd5, 64'd3, 3'd3);
    tbl[20] = mk(6'b01_0000, 64'd5, 64'd3, 3'd2);
    tbl[21] = mk(6'b00_0000, 64'd5, 64'd3, 3'd2);
    tbl[22] = mk(6'b00_0100, 64'd5, 64'd4, 3'd2);
    tbl[23] = mk(6'b01_0000, 64'd5, 64'd4, 3'd1);
    tbl[24] = mk(6'b00_0000, 64'd5, 64'd4, 3'd1);
    tbl[25] = mk(6'b00_0100, 64'd5, 64'd5, 3'd1);
    tbl[26] = mk(6'b01_0001, 64'd5, 64'd5, 3'd0);
    tbl[27] = mk(6'b00_0001, 64'd5, 64'd5, 3'd0);

    for (int k = 0; k < 10; k++) begin
      sw[k] = 64'hF00D_0000_0000_0000 + 64'(k) * 64'h0101_0101_0101;
    end

    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("rst_dut4", {ain0, rout0, full0, empty0, dout0}, {4'b0001, 64'h0});
    chk("rst_dut3", {ain1, rout1, full1, empty1, dout1}, {4'b0001, 64'h0});

    for (int i = 0; i < 28; i++) begin
      rin0  = tbl[i].ctl[5];
      aout0 = tbl[i].ctl[4];
      din0  = tbl[i].din;
      tick();
      chk($sformatf("vec%0d", i), {ain0, rout0, full0, empty0, dout0},
          {tbl[i].ctl[3:0], tbl[i].dout});
`ifdef HS_STATUS_EN
      chk($sformatf("vec%0d_level", i), lvl0, tbl[i].lvl);
      chk($sformatf("vec%0d_perr", i), perr0, 0);
`endif
    end
    rin0 = 0; aout0 = 0;

    // Asynchronous reset with two words buffered and both handshakes active.
    push0(64'hB1B1_B1B1_B1B1_B1B1);
    din0 = 64'hB2B2_B2B2_B2B2_B2B2;
    rin0 = 1'b1;
    tick();
    chk("pre_rst", {ain0, rout0, empty0, dout0}, {3'b110, 64'hB1B1_B1B1_B1B1_B1B1});
    #2 reset = 1'b0;
    #1 chk("async_rst", {ain0, rout0, full0, empty0, dout0}, {4'b0001, 64'h0});
    rin0 = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst%0d", i), {rout0, empty0}, 2'b01);
    end
    push0(64'hC3C3_0000_0000_00C3);
    begin
      int n;
      n = 0;
      while (rout0 !== 1'b1 && n < 20) begin tick(); n++; end
    end
    chk("post_rst_data", {rout0, dout0}, {1'b1, 64'hC3C3_0000_0000_00C3});
    aout0 = 1'b1; tick();
    aout0 = 1'b0; tick();
    chk("post_rst_empty", empty0, 1);

    // DEPTH=3 streaming with a randomly slow consumer.
    fork
      begin : prod
        int n;
        for (int k = 0; k < 10; k++) begin
          din1 = sw[k];
          rin1 = 1'b1;
          n = 0;
          while (ain1 !== 1'b1 && n < 100) begin tick(); n++; end
          chk($sformatf("s_ack%0d", k), ain1, 1);
          rin1 = 1'b0;
          n = 0;
          while (ain1 !== 1'b0 && n < 20) begin tick(); n++; end
        end
        prod_done = 1'b1;
      end
      begin : cons
        int n;
        for (int k = 0; k < 10; k++) begin
          n = 0;
          while (rout1 !== 1'b1 && n < 100) begin tick(); n++; end
          chk($sformatf("s_data%0d", k), {rout1, dout1}, {1'b1, sw[k]});
          repeat ($urandom_range(0, 3)) tick();
          aout1 = 1'b1;
          n = 0;
          while (rout1 !== 1'b0 && n < 20) begin tick(); n++; end
          aout1 = 1'b0;
        end
        cons_done = 1'b1;
      end
      begin : mon
        int occ, cyc;
        logic pa, pr;
        occ = 0; cyc = 0; pa = 1'b0; pr = 1'b0;
        while (!(prod_done && cons_done) && cyc < 3000) begin
          tick();
          cyc++;
          if (ain1 && !pa) occ++;
          if (!rout1 && pr) occ--;
          pa = ain1;
          pr = rout1;
          chk("s_flags", {occ > 3, full1, empty1}, {1'b0, occ == 3, occ == 0});
`ifdef HS_STATUS_EN
          chk("s_level", lvl1, 2'(occ));
`endif
        end
        chk("s_done", {prod_done, cons_done}, 2'b11);
      end
    join
    tick();
    tick();
    chk("s_empty_end", {full1, empty1, rout1}, 3'b010);

`ifdef HS_STATUS_EN
    chk("s_perr_clean", perr1, 0);
    aout1 = 1'b1;
    tick();
    aout1 = 1'b0;
    chk("stray_ack_perr", perr1, 1);

    // Request withdrawn while full and unacknowledged.
    for (int i = 0; i < 4; i++) push0(64'hD0 + 64'(i));
    chk("pe_full", {full0, lvl0, perr0}, {1'b1, 3'd4, 1'b0});
    din0 = 64'hDEAD;
    rin0 = 1'b1;
    tick();
    chk("pe_refused", {ain0, perr0}, 2'b00);
    rin0 = 1'b0;
    tick();
    chk("pe_set", perr0, 1);
    repeat (3) tick();
    chk("pe_sticky", {perr0, lvl0}, {1'b1, 3'd4});
    #2 reset = 1'b0;
    #1 chk("pe_cleared", {perr0, perr1, lvl0}, {2'b00, 3'd0});
    tick();
    reset = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
